// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: widths, channel map, grant modes.
package arb_defs;

  localparam int unsigned WORD_WIDTH = 16;

  // Channel indices in priority-table order
  localparam int unsigned CH_LEARN_COST       = 0;
  localparam int unsigned CH_AM_I_SINK        = 1;
  localparam int unsigned CH_FIX_SINK_LIST    = 2;
  localparam int unsigned CH_NEIGHBOR_SINK    = 3;
  localparam int unsigned CH_FIND_MY_BEST     = 4;
  localparam int unsigned CH_BETTER_NEIGHBORS = 5;
  localparam int unsigned CH_WINNER_POLICY    = 6;
  localparam int unsigned CH_SELECT_MY_ACTION = 7;

  localparam logic ARB_MODE_SELECT = 1'b0;
  localparam logic ARB_MODE_RR     = 1'b1;

  // Ceiling log2, minimum 1 so a 2-channel index is still one bit wide
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter
  import arb_defs::*;
#(
  parameter int unsigned NUM_CH = 8,
  localparam int unsigned SEL_W = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt_c,
  output logic [SEL_W-1:0]  idx_c
);

  int unsigned      cand;
  logic [SEL_W-1:0] cand_idx;
  logic             found;

  // Scan ptr+1 .. ptr+NUM_CH (mod NUM_CH); the first hit wins
  always_comb begin
    gnt_c    = '0;
    idx_c    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand     = (32'(ptr) + k) % NUM_CH;
      cand_idx = SEL_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        gnt_c[cand_idx] = 1'b1;
        idx_c           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_CH units; issues registered accesses and steers read data back.
module mem_port_arbiter #(
  parameter int unsigned WORD_WIDTH = arb_defs::WORD_WIDTH,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned MEM_LAT    = 1,
  localparam int unsigned SEL_W     = arb_defs::clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         arb_mode,
  input  logic [SEL_W-1:0]             select,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr_en,
  input  logic [NUM_CH*WORD_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*WORD_WIDTH-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_rd_valid,
  output logic [WORD_WIDTH-1:0]        ch_rd_data,
  output logic                         mem_en,
  output logic                         mem_wr_en,
  output logic [WORD_WIDTH-1:0]        mem_addr,
  output logic [WORD_WIDTH-1:0]        mem_wr_data,
  input  logic [WORD_WIDTH-1:0]        mem_rd_data
);

  logic [SEL_W-1:0]      ptr_q;
  logic [NUM_CH-1:0]     rr_gnt;
  logic [SEL_W-1:0]      rr_idx;
  logic [NUM_CH-1:0]     sel_gnt;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  xfer;
  logic [NUM_CH-1:0]     rd_xfer;
  logic                  iss_wr_en;
  logic [WORD_WIDTH-1:0] iss_addr;
  logic [WORD_WIDTH-1:0] iss_wr_data;
  // One-hot read tags, stage 0 aligned with mem_en
  logic [NUM_CH-1:0]     tag_q [MEM_LAT];

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req   (ch_req),
    .ptr   (ptr_q),
    .gnt_c (rr_gnt),
    .idx_c (rr_idx)
  );

  // Select-driven grant; out-of-range indices grant nobody
  always_comb begin
    sel_gnt = '0;
    if (32'(select) < NUM_CH) sel_gnt[select] = ch_req[select];
  end

  assign ch_gnt  = (rst || !en) ? '0 :
                   (arb_mode == arb_defs::ARB_MODE_RR) ? rr_gnt : sel_gnt;
  assign gnt_idx = (arb_mode == arb_defs::ARB_MODE_RR) ? rr_idx : select;
  assign xfer    = |(ch_req & ch_gnt);
  assign rd_xfer = ch_req & ch_gnt & ~ch_wr_en;

  // Route the granted channel's request fields to the issue registers
  always_comb begin
    iss_wr_en   = 1'b0;
    iss_addr    = '0;
    iss_wr_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_gnt[i]) begin
        iss_wr_en   = ch_wr_en[i];
        iss_addr    = ch_addr[i*WORD_WIDTH +: WORD_WIDTH];
        iss_wr_data = ch_wr_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Priority pointer follows the last granted channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr_q <= SEL_W'(NUM_CH - 1);
    else if (xfer) ptr_q <= gnt_idx;
  end

  // Issue stage: strobe every transfer, hold fields when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_en <= xfer;
      if (xfer) begin
        mem_wr_en   <= iss_wr_en;
        mem_addr    <= iss_addr;
        mem_wr_data <= iss_wr_data;
      end
    end
  end

  // Tag pipeline tracks outstanding reads; runs regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MEM_LAT; k++) tag_q[k] <= '0;
      ch_rd_valid <= '0;
    end else begin
      tag_q[0] <= rd_xfer;
      for (int unsigned k = 1; k < MEM_LAT; k++) tag_q[k] <= tag_q[k-1];
      ch_rd_valid <= tag_q[MEM_LAT-1];
    end
  end

  assign ch_rd_data = mem_rd_data;

endmodule
